// File: rtl/sha256_pkg.sv
// Shared types, sizes and small-sigma functions for the SHA-256 message schedule.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int BLK_WORDS   = 16;
  localparam int SCHED_WORDS = 64;
  localparam int IDX_W       = 6;

  typedef enum logic {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } sched_state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_window.sv
// 16-word sliding window of the most recent schedule words; entry 15 is newest, 0 is oldest.
module sha256_msg_window
  import sha256_pkg::*;
(
  input  logic  clk,
  input  logic  shift_en,
  input  word_t shift_in,
  output word_t win0,
  output word_t win1,
  output word_t win9,
  output word_t win14
);

  word_t win_q [BLK_WORDS];

  // Contents are don't-care after reset, so the window carries no reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int i = 0; i < BLK_WORDS - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[BLK_WORDS-1] <= shift_in;
    end
  end

  assign win0  = win_q[0];
  assign win1  = win_q[1];
  assign win9  = win_q[9];
  assign win14 = win_q[14];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: takes W0..W15 serially, expands and streams W0..W63.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_word,
  output logic [5:0]   out_idx,
  output logic         out_last,
  output logic         busy,
  output sched_state_t state_dbg
);

  // Handshakes: a word moves on a rising edge where valid & ready are both high.
  // valid never waits on ready; out_word/out_idx/out_last hold while out_valid & !out_ready.

  localparam logic [IDX_W-1:0] LAST_BLK   = IDX_W'(BLK_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SCHED = IDX_W'(SCHED_WORDS - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] t_q, t_d;
  logic             out_valid_q, out_last_q, busy_q;
  word_t            out_word_q;
  logic [IDX_W-1:0] out_idx_q;

  logic  out_free;
  logic  load_out;
  word_t load_data;
  word_t w_new;
  word_t win0, win1, win9, win14;

  sha256_msg_window u_window (
    .clk      (clk),
    .shift_en (load_out),
    .shift_in (load_data),
    .win0     (win0),
    .win1     (win1),
    .win9     (win9),
    .win14    (win14)
  );

  assign w_new = ssig1(win14) + win9 + ssig0(win1) + win0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_out && t_q == LAST_BLK)   state_d = EXPAND;
      EXPAND:  if (load_out && t_q == LAST_SCHED) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // FSM outputs: a word enters the output register either from the input or from the expander
  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = 1'b0;
    load_out  = 1'b0;
    load_data = w_new;
    case (state_q)
      LOAD: begin
        in_ready  = out_free && !rst;
        load_out  = in_valid && out_free && !rst;
        load_data = in_word;
      end
      EXPAND: begin
        load_out = out_free;
      end
      default: ;
    endcase
  end

  assign t_d = load_out ? t_q + 1'b1 : t_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      t_q    <= t_d;
      busy_q <= (state_d != LOAD) || (t_d != '0);
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_word_q  <= load_data;
        out_idx_q   <= t_q;
        out_last_q  <= (t_q == LAST_SCHED);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: reset, "abc" block, sigma0, back-pressure, back-to-back, mid-block reset.
module tb_sha256_msg_sched;
  import sha256_pkg::*;

  typedef logic [31:0] blk_t   [16];
  typedef logic [31:0] sched_t [64];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_word = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_word;
  logic [5:0]   out_idx;
  logic         out_last;
  logic         busy;
  sched_state_t state_dbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] in_q[$];
  logic [31:0] obs_word[$];
  logic [5:0]  obs_idx[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  int          in_cyc[$];
  logic [31:0] hold_word[$];
  logic [5:0]  hold_idx[$];
  bit          timed_out;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Golden model, written in array-index form
  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic model(input blk_t b, output sched_t w);
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
  endtask

  task automatic push_block(input blk_t b);
    sched_t w;
    model(b, w);
    for (int i = 0; i < 16; i++) in_q.push_back(b[i]);
    for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
  endtask

  task automatic rand_block(output blk_t b);
    for (int i = 0; i < 16; i++) b[i] = $urandom;
  endtask

  // Driver: feeds in_q, applies an optional stall at one index, records every transfer.
  task automatic drive(input int n_out, input int stall_at, input int stall_len, input int gap_pct);
    int cyc = 0;
    int stall_left = 0;
    bit stall_done = 0;
    obs_word.delete(); obs_idx.delete(); obs_last.delete(); obs_cyc.delete();
    in_cyc.delete(); hold_word.delete(); hold_idx.delete();
    timed_out = 0;
    while (obs_word.size() < n_out && cyc < 3000) begin
      @(negedge clk);
      if (stall_at >= 0 && !stall_done && out_valid && out_idx == 6'(stall_at)) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        hold_word.push_back(out_word);
        hold_idx.push_back(out_idx);
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (in_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_word  = in_q[0];
      end else begin
        in_valid = 1'b0;
        in_word  = $urandom;
      end
      #1;
      if (out_valid && out_ready) begin
        obs_word.push_back(out_word);
        obs_idx.push_back(out_idx);
        obs_last.push_back(out_last);
        obs_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        in_cyc.push_back(cyc);
        void'(in_q.pop_front());
      end
      cyc++;
    end
    if (obs_word.size() < n_out) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_high: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_word !== 32'h0) $display("FAIL rst_out_word: got %h want 0", out_word); else pass_cnt++;
    chk_cnt++; if (out_idx !== 6'd0) $display("FAIL rst_out_idx: got %0d want 0", out_idx); else pass_cnt++;
    chk_cnt++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_after: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (state_dbg !== LOAD) $display("FAIL rst_state: got %0d want LOAD", state_dbg); else pass_cnt++;
  endtask

  task automatic test_abc();
    blk_t b = '{default: 32'h0};
    logic [31:0] e;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    push_block(b);
    drive(64, -1, 0, 0);
    chk_cnt++; if (timed_out) $display("FAIL abc_timeout: got %0d words want 64", obs_word.size()); else pass_cnt++;
    if (!timed_out) begin
      for (int k = 0; k < 16; k++) begin
        chk_cnt++; if (obs_word[k] !== b[k]) $display("FAIL abc_echo[%0d]: got %h want %h", k, obs_word[k], b[k]); else pass_cnt++;
        chk_cnt++; if (obs_cyc[k] !== in_cyc[k] + 1) $display("FAIL abc_in_latency[%0d]: got cycle %0d want %0d", k, obs_cyc[k], in_cyc[k] + 1); else pass_cnt++;
      end
      chk_cnt++; if (obs_word[16] !== 32'h61626380) $display("FAIL abc_w16: got %h want 61626380", obs_word[16]); else pass_cnt++;
      chk_cnt++; if (obs_word[17] !== 32'h000F0000) $display("FAIL abc_w17: got %h want 000f0000", obs_word[17]); else pass_cnt++;
      chk_cnt++; if (obs_cyc[16] !== obs_cyc[15] + 1) $display("FAIL abc_expand_latency: got cycle %0d want %0d", obs_cyc[16], obs_cyc[15] + 1); else pass_cnt++;
      for (int i = 0; i < 64; i++) begin
        e = exp_q.pop_front();
        chk_cnt++; if (obs_word[i] !== e) $display("FAIL abc_word[%0d]: got %h want %h", i, obs_word[i], e); else pass_cnt++;
        chk_cnt++; if (obs_idx[i] !== 6'(i)) $display("FAIL abc_idx[%0d]: got %0d want %0d", i, obs_idx[i], i); else pass_cnt++;
        chk_cnt++; if (obs_last[i] !== (i == 63)) $display("FAIL abc_last[%0d]: got %b want %b", i, obs_last[i], (i == 63)); else pass_cnt++;
      end
    end
    exp_q.delete(); in_q.delete();
  endtask

  task automatic test_sigma0();
    blk_t b = '{default: 32'h0};
    logic [31:0] e;
    b[1] = 32'hFFFFFFFF;
    push_block(b);
    drive(64, -1, 0, 0);
    chk_cnt++; if (timed_out) $display("FAIL s0_timeout: got %0d words want 64", obs_word.size()); else pass_cnt++;
    if (!timed_out) begin
      chk_cnt++; if (obs_word[16] !== 32'h1FFFFFFF) $display("FAIL s0_w16: got %h want 1fffffff", obs_word[16]); else pass_cnt++;
      for (int i = 0; i < 64; i++) begin
        e = exp_q.pop_front();
        chk_cnt++; if (obs_word[i] !== e) $display("FAIL s0_word[%0d]: got %h want %h", i, obs_word[i], e); else pass_cnt++;
      end
    end
    exp_q.delete(); in_q.delete();
  endtask

  task automatic test_backpressure();
    blk_t b;
    sched_t w;
    logic [31:0] e;
    rand_block(b);
    model(b, w);
    push_block(b);
    drive(64, 20, 5, 40);
    chk_cnt++; if (timed_out) $display("FAIL bp_timeout: got %0d words want 64", obs_word.size()); else pass_cnt++;
    chk_cnt++; if (hold_word.size() != 5) $display("FAIL bp_stall_len: got %0d want 5", hold_word.size()); else pass_cnt++;
    for (int k = 0; k < hold_word.size(); k++) begin
      chk_cnt++; if (hold_word[k] !== w[20]) $display("FAIL bp_hold_word[%0d]: got %h want %h", k, hold_word[k], w[20]); else pass_cnt++;
      chk_cnt++; if (hold_idx[k] !== 6'd20) $display("FAIL bp_hold_idx[%0d]: got %0d want 20", k, hold_idx[k]); else pass_cnt++;
    end
    if (!timed_out) begin
      chk_cnt++; if (obs_cyc[20] - obs_cyc[19] != 6) $display("FAIL bp_stall_gap: got %0d cycles want 6", obs_cyc[20] - obs_cyc[19]); else pass_cnt++;
      for (int i = 0; i < 64; i++) begin
        e = exp_q.pop_front();
        chk_cnt++; if (obs_word[i] !== e) $display("FAIL bp_word[%0d]: got %h want %h", i, obs_word[i], e); else pass_cnt++;
        chk_cnt++; if (obs_idx[i] !== 6'(i)) $display("FAIL bp_idx[%0d]: got %0d want %0d", i, obs_idx[i], i); else pass_cnt++;
      end
    end
    exp_q.delete(); in_q.delete();
  endtask

  task automatic test_back_to_back();
    blk_t b0, b1;
    logic [31:0] e;
    rand_block(b0);
    rand_block(b1);
    push_block(b0);
    push_block(b1);
    drive(128, -1, 0, 0);
    chk_cnt++; if (timed_out) $display("FAIL b2b_timeout: got %0d words want 128", obs_word.size()); else pass_cnt++;
    chk_cnt++; if (in_cyc.size() != 32) $display("FAIL b2b_inputs: got %0d want 32", in_cyc.size()); else pass_cnt++;
    if (!timed_out && in_cyc.size() == 32) begin
      chk_cnt++; if (in_cyc[16] !== obs_cyc[63]) $display("FAIL b2b_w0_overlap: got cycle %0d want %0d", in_cyc[16], obs_cyc[63]); else pass_cnt++;
      for (int i = 0; i < 127; i++) begin
        chk_cnt++; if (obs_cyc[i+1] !== obs_cyc[i] + 1) $display("FAIL b2b_bubble[%0d]: got cycle %0d want %0d", i + 1, obs_cyc[i+1], obs_cyc[i] + 1); else pass_cnt++;
      end
      for (int i = 0; i < 128; i++) begin
        e = exp_q.pop_front();
        chk_cnt++; if (obs_word[i] !== e) $display("FAIL b2b_word[%0d]: got %h want %h", i, obs_word[i], e); else pass_cnt++;
        chk_cnt++; if (obs_idx[i] !== 6'(i % 64)) $display("FAIL b2b_idx[%0d]: got %0d want %0d", i, obs_idx[i], i % 64); else pass_cnt++;
        chk_cnt++; if (obs_last[i] !== (i % 64 == 63)) $display("FAIL b2b_last[%0d]: got %b want %b", i, obs_last[i], (i % 64 == 63)); else pass_cnt++;
      end
    end
    exp_q.delete(); in_q.delete();
  endtask

  task automatic test_reset_mid();
    blk_t b;
    blk_t a = '{default: 32'h0};
    logic [31:0] e;
    rand_block(b);
    push_block(b);
    drive(40, -1, 0, 0);
    chk_cnt++; if (timed_out) $display("FAIL rm_timeout: got %0d words want 40", obs_word.size()); else pass_cnt++;
    for (int i = 0; i < obs_word.size(); i++) begin
      e = exp_q.pop_front();
      chk_cnt++; if (obs_word[i] !== e) $display("FAIL rm_word[%0d]: got %h want %h", i, obs_word[i], e); else pass_cnt++;
    end
    @(negedge clk);
    #1;
    chk_cnt++; if (out_idx !== 6'd40 || out_valid !== 1'b1) $display("FAIL rm_pre_idx: got valid=%b idx=%0d want valid=1 idx=40", out_valid, out_idx); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL rm_pre_busy: got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if (state_dbg !== EXPAND) $display("FAIL rm_pre_state: got %0d want EXPAND", state_dbg); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_in_ready_rst: got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_idx !== 6'd0) $display("FAIL rm_out_idx: got %0d want 0", out_idx); else pass_cnt++;
    exp_q.delete(); in_q.delete();
    a[0]  = 32'h61626380;
    a[15] = 32'h00000018;
    push_block(a);
    drive(64, -1, 0, 0);
    chk_cnt++; if (timed_out) $display("FAIL rm_restart_timeout: got %0d words want 64", obs_word.size()); else pass_cnt++;
    if (!timed_out) begin
      for (int i = 0; i < 64; i++) begin
        e = exp_q.pop_front();
        chk_cnt++; if (obs_word[i] !== e) $display("FAIL rm_restart_word[%0d]: got %h want %h", i, obs_word[i], e); else pass_cnt++;
        chk_cnt++; if (obs_idx[i] !== 6'(i)) $display("FAIL rm_restart_idx[%0d]: got %0d want %0d", i, obs_idx[i], i); else pass_cnt++;
      end
    end
    exp_q.delete(); in_q.delete();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_sigma0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
